tty_iot_device: RTL and testbench

//  Console teletype device consuming the IOT decoder's device selects 603x (keyboard)
//  and 604x (teleprinter) plus the IR[2:0] micro-op bits. Owns keyboard/printer flags
//  and buffers, drives SKIP / AC clear / AC read-in toward the CPU datapath, and

---
 rtl/tty_iot_device.sv | 154 +++++++++++++++
 tb/tb_tty_iot_device.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tty_iot_device.sv
// Console teletype on IOT device codes 603x (keyboard) and 604x (teleprinter).
// Holds the keyboard/printer flags and buffers and trades bytes with a UART over valid/ready.
module tty_iot_device #(
  parameter int PRINT_DELAY = 16,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       IOT603x,
  input  logic       IOT604x,
  input  logic [2:0] IR,
  input  logic       EXEC,
  input  logic [7:0] AC,
  output logic       SKIP,
  output logic       AC_CLR,
  output logic       KBD_OE,
  output logic [7:0] KBD_DATA,
  output logic       IRQ,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  output logic       RX_READY,
  output logic [7:0] TX_DATA,
  output logic       TX_VALID,
  input  logic       TX_READY,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_SEND = 2'd1,
    P_WAIT = 2'd2
  } p_state_t;

  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(PRINT_DELAY);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  p_state_t         state;
  p_state_t         state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             kbd_flag;
  logic             tty_flag;

  logic kbd_sel;
  logic prt_sel;
  logic kbd_clr;
  logic prt_clr;
  logic prt_set;
  logic print_op;
  logic rx_accept;

  logic tx_load;
  logic cnt_load;
  logic cnt_dec;
  logic fsm_flag_set;

  // IOT decode; SKIP reads the flag value from before the execute edge.
  assign kbd_sel  = EXEC & IOT603x;
  assign prt_sel  = EXEC & IOT604x;
  assign kbd_clr  = kbd_sel & (IR[1] | (IR == 3'b000));
  assign prt_clr  = prt_sel & IR[1];
  assign prt_set  = prt_sel & (IR == 3'b000);
  assign print_op = prt_sel & IR[2];

  assign SKIP   = (kbd_sel & IR[0] & kbd_flag) | (prt_sel & IR[0] & tty_flag);
  assign AC_CLR = kbd_sel & IR[1];
  assign KBD_OE = kbd_sel & IR[2];
  assign IRQ    = kbd_flag | tty_flag;

  // Valid/ready: a byte moves on any rising edge where both valid and ready are high;
  // the source holds data and valid steady until that edge.
  assign RX_READY  = ~kbd_flag;
  assign rx_accept = RX_VALID & RX_READY;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbd_flag <= 1'b0;
      KBD_DATA <= 8'h00;
    end else begin
      if (rx_accept) begin
        KBD_DATA <= RX_DATA;
        kbd_flag <= 1'b1;
      end else if (kbd_clr) begin
        kbd_flag <= 1'b0;
      end
    end
  end

  // Printer flag: a set from the FSM or from SPF beats a same-edge clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tty_flag <= 1'b0;
    end else if (fsm_flag_set | prt_set) begin
      tty_flag <= 1'b1;
    end else if (prt_clr) begin
      tty_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= P_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      P_IDLE: if (print_op) state_nxt = P_SEND;
      P_SEND: if (TX_READY) state_nxt = P_WAIT;
      P_WAIT: if (cnt == '0) state_nxt = P_IDLE;
      default: state_nxt = P_IDLE;
    endcase
  end

  always_comb begin
    TX_VALID     = 1'b0;
    tx_load      = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    fsm_flag_set = 1'b0;
    case (state)
      P_IDLE: tx_load = print_op;
      P_SEND: begin
        TX_VALID = 1'b1;
        cnt_load = TX_READY;
      end
      P_WAIT: begin
        cnt_dec      = (cnt != '0);
        fsm_flag_set = (cnt == '0);
      end
      default: ;
    endcase
  end

  // Print requests outside P_IDLE never reach tx_load, so TX_DATA is not disturbed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      TX_DATA <= 8'h00;
      cnt     <= '0;
    end else begin
      if (tx_load) TX_DATA <= AC;
      if (cnt_load) begin
        cnt <= DELAY_LOAD;
      end else if (cnt_dec) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_tty_iot_device.sv
// Directed bench for tty_iot_device: keyboard path, printer FSM timing, IOT decode, async reset.
module tb_tty_iot_device;

  localparam int PD = 16;

  logic       clk;
  logic       reset;
  logic       IOT603x;
  logic       IOT604x;
  logic [2:0] IR;
  logic       EXEC;
  logic [7:0] AC;
  logic       SKIP;
  logic       AC_CLR;
  logic       KBD_OE;
  logic [7:0] KBD_DATA;
  logic       IRQ;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_READY;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;
  logic [1:0] fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  tty_iot_device #(.PRINT_DELAY(PD), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .IOT603x(IOT603x), .IOT604x(IOT604x), .IR(IR), .EXEC(EXEC),
    .AC(AC), .SKIP(SKIP), .AC_CLR(AC_CLR), .KBD_OE(KBD_OE), .KBD_DATA(KBD_DATA), .IRQ(IRQ),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY), .TX_DATA(TX_DATA),
    .TX_VALID(TX_VALID), .TX_READY(TX_READY), .fsm_state(fsm_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then return at the falling edge where inputs are driven.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic iot(input logic k, input logic p, input logic [2:0] ir, input logic ex);
    IOT603x = k;
    IOT604x = p;
    IR      = ir;
    EXEC    = ex;
    #1;
  endtask

  initial begin
    reset = 1'b1; IOT603x = 0; IOT604x = 0; IR = 3'b000; EXEC = 0; AC = 8'h00;
    RX_DATA = 8'h00; RX_VALID = 0; TX_READY = 0;
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_irq", 16'(IRQ), 16'h0);
    check("rst_tx_valid", 16'(TX_VALID), 16'h0);
    check("rst_tx_data", 16'(TX_DATA), 16'h00);
    check("rst_kbd_data", 16'(KBD_DATA), 16'h00);
    check("rst_rx_ready", 16'(RX_READY), 16'h1);
    check("rst_state", 16'(fsm_state), 16'h0);
    reset = 1'b0;
    step();

    // Keyboard receive, then a second byte held off by the full buffer
    RX_DATA = 8'h41; RX_VALID = 1'b1;
    #1;
    check("rx_ready_pre", 16'(RX_READY), 16'h1);
    step();
    RX_DATA = 8'h42;
    #1;
    check("kbd_flag_irq", 16'(IRQ), 16'h1);
    check("rx_ready_busy", 16'(RX_READY), 16'h0);
    check("kbd_data_41", 16'(KBD_DATA), 16'h41);

    iot(1, 0, 3'b001, 1);
    check("6031_skip", 16'(SKIP), 16'h1);
    check("6031_acclr", 16'(AC_CLR), 16'h0);
    check("6031_oe", 16'(KBD_OE), 16'h0);
    step();

    iot(1, 0, 3'b110, 0);
    check("noexec_skip", 16'(SKIP), 16'h0);
    check("noexec_acclr", 16'(AC_CLR), 16'h0);
    check("noexec_oe", 16'(KBD_OE), 16'h0);
    step();
    check("noexec_flag_kept", 16'(IRQ), 16'h1);
    check("no_overwrite", 16'(KBD_DATA), 16'h41);

    iot(1, 0, 3'b110, 1);
    check("6036_acclr", 16'(AC_CLR), 16'h1);
    check("6036_oe", 16'(KBD_OE), 16'h1);
    check("6036_skip", 16'(SKIP), 16'h0);
    check("6036_data", 16'(KBD_DATA), 16'h41);
    step();
    iot(0, 0, 3'b000, 0);
    check("6036_flag_clr", 16'(IRQ), 16'h0);
    check("6036_rx_ready", 16'(RX_READY), 16'h1);
    check("6036_data_held", 16'(KBD_DATA), 16'h41);
    step();
    RX_VALID = 1'b0;
    #1;
    check("second_byte", 16'(KBD_DATA), 16'h42);
    check("second_flag", 16'(IRQ), 16'h1);

    iot(1, 0, 3'b000, 1);
    check("6030_acclr", 16'(AC_CLR), 16'h0);
    check("6030_oe", 16'(KBD_OE), 16'h0);
    step();
    iot(0, 0, 3'b000, 0);
    check("6030_flag_clr", 16'(IRQ), 16'h0);
    check("6030_data_kept", 16'(KBD_DATA), 16'h42);

    // Printer: 6046 with a stalled transmitter
    AC = 8'h5A;
    iot(0, 1, 3'b110, 1);
    check("6046_skip", 16'(SKIP), 16'h0);
    step();
    iot(0, 0, 3'b000, 0);
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 16'(TX_VALID), 16'h1);
      check("stall_data", 16'(TX_DATA), 16'h5A);
      step();
    end
    check("stall_state", 16'(fsm_state), 16'h1);
    TX_READY = 1'b1;
    step();
    TX_READY = 1'b0;
    #1;
    check("hs_valid_drop", 16'(TX_VALID), 16'h0);
    check("hs_state_wait", 16'(fsm_state), 16'h2);

    AC = 8'h33;
    iot(0, 1, 3'b100, 1);
    step();
    iot(0, 0, 3'b000, 0);
    check("6044_ignored_data", 16'(TX_DATA), 16'h5A);
    check("6044_ignored_valid", 16'(TX_VALID), 16'h0);
    for (int i = 2; i <= PD; i++) begin
      step();
      check("wait_no_flag", 16'(IRQ), 16'h0);
      check("wait_no_tx", 16'(TX_VALID), 16'h0);
    end
    // Clear request lands on the edge where the delay expires; the set must win
    iot(0, 1, 3'b010, 1);
    step();
    iot(0, 0, 3'b000, 0);
    check("flag_at_pd_plus1", 16'(IRQ), 16'h1);
    check("back_idle", 16'(fsm_state), 16'h0);

    iot(0, 1, 3'b001, 1);
    check("6041_skip", 16'(SKIP), 16'h1);
    step();
    iot(0, 1, 3'b010, 1);
    step();
    iot(0, 1, 3'b001, 1);
    check("6041_after_clr", 16'(SKIP), 16'h0);
    check("6042_irq", 16'(IRQ), 16'h0);
    step();
    iot(0, 1, 3'b000, 1);
    step();
    iot(0, 1, 3'b010, 0);
    check("6040_set", 16'(IRQ), 16'h1);
    step();
    iot(0, 0, 3'b000, 0);
    check("noexec_prt_kept", 16'(IRQ), 16'h1);

    // Async reset in the middle of a transmit
    RX_DATA = 8'h55; RX_VALID = 1'b1;
    AC = 8'h77;
    iot(0, 1, 3'b100, 1);
    step();
    RX_VALID = 1'b0;
    iot(0, 0, 3'b000, 0);
    check("send_before_rst", 16'(TX_VALID), 16'h1);
    check("send_data_77", 16'(TX_DATA), 16'h77);
    reset = 1'b1;
    #1;
    check("arst_valid", 16'(TX_VALID), 16'h0);
    check("arst_irq", 16'(IRQ), 16'h0);
    check("arst_state", 16'(fsm_state), 16'h0);
    check("arst_tx_data", 16'(TX_DATA), 16'h00);
    check("arst_kbd_data", 16'(KBD_DATA), 16'h00);
    step();
    reset = 1'b0;
    TX_READY = 1'b1;
    step();
    TX_READY = 1'b0;
    #1;
    check("post_rst_rx_ready", 16'(RX_READY), 16'h1);
    check("post_rst_no_tx", 16'(TX_VALID), 16'h0);
    check("post_rst_irq", 16'(IRQ), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
